// File: rtl/bank_sched_pkg.sv
// Shared defaults and types for the bank occupancy scheduler.
// The optional conflict statistics counter is enabled with BANK_OCC_STATS_EN.
package bank_sched_pkg;

  localparam int DEF_VEC    = 16;
  localparam int DEF_NBANK  = 32;
  localparam int DEF_BANK_W = $clog2(DEF_NBANK);
  localparam int DEF_LANE_W = $clog2(DEF_VEC + 1);
  localparam logic [DEF_LANE_W-1:0] NONE_LANE = DEF_LANE_W'(DEF_VEC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/bank_lane_select.sv
// Picks the lowest-index pending lane addressing one bank and returns it
// both as a lane index (VEC when no lane matches) and as a one-hot grant.
module bank_lane_select #(
  parameter int VEC    = 16,
  parameter int BANK_W = 5,
  parameter int LANE_W = 5
) (
  input  logic [VEC-1:0]        pending,
  input  logic [VEC*BANK_W-1:0] bank,
  input  logic [BANK_W-1:0]     bank_id,
  output logic [LANE_W-1:0]     lane,
  output logic [VEC-1:0]        grant
);

  logic [VEC-1:0] hit;
  logic [VEC-1:0] one;

  assign one = {{(VEC-1){1'b0}}, 1'b1};

  // Scan from the top lane down so the lowest matching lane is the final writer.
  always_comb begin
    lane  = LANE_W'(VEC);
    grant = '0;
    hit   = '0;
    for (int i = VEC - 1; i >= 0; i--) begin
      hit[i] = pending[i] && (bank[i*BANK_W +: BANK_W] == bank_id);
      lane   = hit[i] ? LANE_W'(i) : lane;
      grant  = hit[i] ? (one << i) : grant;
    end
  end

endmodule

// File: rtl/bank_occupancy_scheduler.sv
// Resolves bank conflicts in a vector of lane bank addresses over several beats,
// granting each bank to at most one lane per beat. Optional macro: BANK_OCC_STATS_EN.
module bank_occupancy_scheduler
  import bank_sched_pkg::*;
#(
  parameter int VEC   = DEF_VEC,
  parameter int NBANK = DEF_NBANK,
  localparam int BANK_W = $clog2(NBANK),
  localparam int LANE_W = $clog2(VEC + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [VEC*BANK_W-1:0]   in_bank,
  input  logic [VEC-1:0]          in_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NBANK*LANE_W-1:0] out_lane,
  output logic [NBANK-1:0]        out_occupied,
  output logic                    out_last,
  output logic [31:0]             conflict_cnt
);

  localparam logic [LANE_W-1:0]       NONE     = LANE_W'(VEC);
  localparam logic [NBANK*LANE_W-1:0] ALL_NONE = {NBANK{NONE}};

  state_e                  state_q, state_d;
  logic [VEC*BANK_W-1:0]   bank_q, bank_d;
  logic [VEC-1:0]          pending_q, pending_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [NBANK*LANE_W-1:0] out_lane_q, out_lane_d;
  logic [NBANK-1:0]        out_occ_q, out_occ_d;

  logic [LANE_W-1:0]       sel_lane [NBANK];
  logic [VEC-1:0]          sel_grant [NBANK];
  logic [VEC-1:0]          grant_all;
  logic [NBANK*LANE_W-1:0] lane_pack;
  logic [NBANK-1:0]        occ_pack;
  logic [VEC-1:0]          bad_bank;
  logic [VEC-1:0]          post_pending;
  logic                    slot_free;
  logic                    accept;
  logic                    issue;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    bank_lane_select #(
      .VEC    (VEC),
      .BANK_W (BANK_W),
      .LANE_W (LANE_W)
    ) u_sel (
      .pending (pending_q),
      .bank    (bank_q),
      .bank_id (BANK_W'(b)),
      .lane    (sel_lane[b]),
      .grant   (sel_grant[b])
    );
  end

  // Addresses beyond the last bank only exist when NBANK is not a power of two.
  if (NBANK < (1 << BANK_W)) begin : g_bad
    always_comb begin
      for (int i = 0; i < VEC; i++) begin
        bad_bank[i] = (bank_q[i*BANK_W +: BANK_W] >= BANK_W'(NBANK));
      end
    end
  end else begin : g_no_bad
    assign bad_bank = '0;
  end

  always_comb begin
    grant_all = '0;
    lane_pack = '0;
    occ_pack  = '0;
    for (int b = 0; b < NBANK; b++) begin
      grant_all                       = grant_all | sel_grant[b];
      lane_pack[b*LANE_W +: LANE_W]   = sel_lane[b];
      occ_pack[b]                     = |sel_grant[b];
    end
  end

  assign in_ready     = (state_q == IDLE) && !rst;
  assign slot_free    = !out_valid_q || out_ready;
  assign accept       = (state_q == IDLE) && in_valid && in_ready;
  assign issue        = (state_q == RESOLVE) && slot_free;
  assign post_pending = pending_q & ~grant_all & ~bad_bank;

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_lane_d  = out_lane_q;
    out_occ_d   = out_occ_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          bank_d    = in_bank;
          pending_d = in_mask;
          state_d   = RESOLVE;
        end else begin
          state_d = IDLE;
        end
      end
      RESOLVE: begin
        if (issue) begin
          out_lane_d  = lane_pack;
          out_occ_d   = occ_pack;
          out_valid_d = 1'b1;
          out_last_d  = (post_pending == '0);
          pending_d   = post_pending;
          state_d     = (post_pending == '0) ? DRAIN : RESOLVE;
        end else begin
          state_d = RESOLVE;
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          out_occ_d   = '0;
          out_lane_d  = ALL_NONE;
          state_d     = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d     = IDLE;
        pending_d   = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_occ_d   = '0;
        out_lane_d  = ALL_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bank_q      <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_lane_q  <= ALL_NONE;
      out_occ_q   <= '0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_lane_q  <= out_lane_d;
      out_occ_q   <= out_occ_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_lane     = out_lane_q;
  assign out_occupied = out_occ_q;

`ifdef BANK_OCC_STATS_EN
  logic        first_pend_q, first_pend_d;
  logic        beat_first_q, beat_first_d;
  logic [31:0] conflict_q, conflict_d;

  // beat_first_q tags the beat currently on the output as the first of its vector.
  always_comb begin
    first_pend_d = first_pend_q;
    beat_first_d = beat_first_q;
    if (accept) begin
      first_pend_d = 1'b1;
    end else if (issue) begin
      first_pend_d = 1'b0;
      beat_first_d = first_pend_q;
    end else begin
      first_pend_d = first_pend_q;
    end
    if (out_valid_q && out_ready && !beat_first_q && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_d = conflict_q + 32'd1;
    end else begin
      conflict_d = conflict_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_pend_q <= 1'b0;
      beat_first_q <= 1'b0;
      conflict_q   <= 32'd0;
    end else begin
      first_pend_q <= first_pend_d;
      beat_first_q <= beat_first_d;
      conflict_q   <= conflict_d;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_bank_occupancy_scheduler.sv
// Table-driven bench for bank_occupancy_scheduler with a beat scoreboard.
module tb_bank_occupancy_scheduler;
  import bank_sched_pkg::*;

  localparam int VEC    = DEF_VEC;
  localparam int NBANK  = DEF_NBANK;
  localparam int BANK_W = DEF_BANK_W;
  localparam int LANE_W = DEF_LANE_W;
  localparam logic [LANE_W-1:0]       NONE     = LANE_W'(VEC);
  localparam logic [NBANK*LANE_W-1:0] ALL_NONE = {NBANK{NONE}};

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [VEC*BANK_W-1:0]   in_bank;
  logic [VEC-1:0]          in_mask;
  logic                    out_valid;
  logic                    out_ready;
  logic [NBANK*LANE_W-1:0] out_lane;
  logic [NBANK-1:0]        out_occupied;
  logic                    out_last;
  logic [31:0]             conflict_cnt;

  bank_occupancy_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bank      (in_bank),
    .in_mask      (in_mask),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lane     (out_lane),
    .out_occupied (out_occupied),
    .out_last     (out_last),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NBANK*LANE_W-1:0] lane;
    logic [NBANK-1:0]        occ;
    logic                    last;
  } beat_t;

  typedef struct {
    logic [VEC*BANK_W-1:0] bank;
    logic [VEC-1:0]        mask;
    int                    stall_beat;
    int                    stall_len;
    int                    exp_beats;
  } vec_t;

  beat_t                   exp_q[$];
  vec_t                    vt[7];
  logic [NBANK*LANE_W-1:0] obs_lane [0:31];
  int                      n_checks = 0;
  int                      n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each beat, every bank takes its lowest-index pending lane.
  task automatic push_expected(input logic [VEC*BANK_W-1:0] bk, input logic [VEC-1:0] mask);
    logic [VEC-1:0] pend;
    beat_t          bt;
    pend = mask;
    for (int guard = 0; guard <= VEC; guard++) begin
      bt.lane = ALL_NONE;
      bt.occ  = '0;
      for (int b = 0; b < NBANK; b++) begin
        for (int i = 0; i < VEC; i++) begin
          if (pend[i] && (int'(bk[i*BANK_W +: BANK_W]) == b) && !bt.occ[b]) begin
            bt.lane[b*LANE_W +: LANE_W] = LANE_W'(i);
            bt.occ[b] = 1'b1;
            pend[i] = 1'b0;
          end
        end
      end
      bt.last = (pend == '0);
      exp_q.push_back(bt);
      if (bt.last) break;
    end
  endtask

  task automatic run_vector(input vec_t v, output int beats);
    int                      n;
    int                      stalled;
    beat_t                   e;
    logic [NBANK*LANE_W-1:0] hold_lane;
    logic [NBANK-1:0]        hold_occ;
    push_expected(v.bank, v.mask);
    @(negedge clk);
    in_valid = 1'b1;
    in_bank  = v.bank;
    in_mask  = v.mask;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("first_beat_latency", out_valid, 0);
    beats = 0;
    stalled = 0;
    hold_lane = '0;
    hold_occ = '0;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        if ((beats + 1 == v.stall_beat) && (stalled < v.stall_len)) begin
          out_ready = 1'b0;
          if (stalled == 0) begin
            hold_lane = out_lane;
            hold_occ  = out_occupied;
          end else begin
            chk("stall_lane_hold", out_lane, hold_lane);
            chk("stall_occ_hold", out_occupied, hold_occ);
          end
          stalled++;
        end else begin
          out_ready = 1'b1;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
            break;
          end
          e = exp_q.pop_front();
          chk("beat_lane", out_lane, e.lane);
          chk("beat_occupied", out_occupied, e.occ);
          chk("beat_last", out_last, e.last);
          if (beats < 32) obs_lane[beats] = out_lane;
          beats++;
          if (out_last) break;
        end
      end
    end
    chk("beat_timeout", n < 400, 1);
    @(negedge clk);
    chk("in_ready_after_last", in_ready, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [VEC*BANK_W-1:0] bk;
    int                    beats;
    int                    n;
    int                    cnt;

    for (int i = 0; i < VEC; i++) bk[i*BANK_W +: BANK_W] = BANK_W'(i);
    vt[0] = '{bank: bk, mask: 16'hFFFF, stall_beat: 0, stall_len: 0, exp_beats: 1};
    vt[2] = '{bank: bk, mask: 16'h0000, stall_beat: 0, stall_len: 0, exp_beats: 1};
    for (int i = 0; i < VEC; i++) bk[i*BANK_W +: BANK_W] = BANK_W'(5);
    vt[1] = '{bank: bk, mask: 16'hFFFF, stall_beat: 0, stall_len: 0, exp_beats: 16};
    vt[3] = '{bank: bk, mask: 16'hFFFF, stall_beat: 2, stall_len: 3, exp_beats: 16};
    for (int i = 0; i < VEC; i++) bk[i*BANK_W +: BANK_W] = BANK_W'(2);
    bk[1*BANK_W +: BANK_W] = BANK_W'(9);
    bk[4*BANK_W +: BANK_W] = BANK_W'(9);
    vt[4] = '{bank: bk, mask: 16'h009B, stall_beat: 0, stall_len: 0, exp_beats: 3};
    for (int i = 0; i < VEC; i++) bk[i*BANK_W +: BANK_W] = BANK_W'(i % 4);
    vt[5] = '{bank: bk, mask: 16'hFFFF, stall_beat: 0, stall_len: 0, exp_beats: 4};
    for (int i = 0; i < VEC; i++) bk[i*BANK_W +: BANK_W] = BANK_W'(31 - i);
    vt[6] = '{bank: bk, mask: 16'h8001, stall_beat: 0, stall_len: 0, exp_beats: 1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_bank = '0;
    in_mask = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_occupied", out_occupied, 0);
    chk("rst_out_lane", out_lane, ALL_NONE);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    for (int k = 0; k < 7; k++) begin
      run_vector(vt[k], beats);
      chk("beat_count", beats, vt[k].exp_beats);
      if (k == 1 || k == 3) begin
        for (int j = 0; j < 16; j++) chk("serial_bank5_lane", obs_lane[j][5*LANE_W +: LANE_W], j);
      end
      if (k == 4) begin
        chk("t5_b1_bank2", obs_lane[0][2*LANE_W +: LANE_W], 0);
        chk("t5_b1_bank9", obs_lane[0][9*LANE_W +: LANE_W], 1);
        chk("t5_b2_bank2", obs_lane[1][2*LANE_W +: LANE_W], 3);
        chk("t5_b2_bank9", obs_lane[1][9*LANE_W +: LANE_W], 4);
        chk("t5_b3_bank2", obs_lane[2][2*LANE_W +: LANE_W], 7);
        chk("t5_b3_bank9", obs_lane[2][9*LANE_W +: LANE_W], 16);
      end
    end

    // Reset in the middle of a 16-beat vector.
    @(negedge clk);
    in_valid = 1'b1;
    in_bank  = vt[1].bank;
    in_mask  = vt[1].mask;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    cnt = 0;
    while (cnt < 2 && n < 50) begin
      @(negedge clk);
      n++;
      if (out_valid) cnt++;
    end
    chk("rst_test_two_beats", cnt, 2);
    @(negedge clk);
    chk("beat3_valid", out_valid, 1);
    chk("beat3_lane5", out_lane[5*LANE_W +: LANE_W], 2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_occupied", out_occupied, 0);
    chk("midrst_out_last", out_last, 0);
    chk("midrst_out_lane", out_lane, ALL_NONE);
    chk("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", in_ready, 1);
    chk("postrst_out_valid", out_valid, 0);

    // A full serial vector after reset: the discarded vector must not reappear.
    run_vector(vt[1], beats);
    chk("postrst_beat_count", beats, 16);
`ifdef BANK_OCC_STATS_EN
    chk("stats_after_serial", conflict_cnt, 15);
`else
    chk("stats_tied_zero", conflict_cnt, 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("stats_cleared", conflict_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
